// File: rtl/pci_wb_master_if.sv
// Request/response and Wishbone-style bus signals of the single-beat PCI-side master.
// The master modport is the block itself; the slave modport is the environment around it.
interface pci_wb_master_if;
    logic        REQ_VALID_I;
    logic        REQ_READY_O;
    logic [31:0] REQ_ADD_I;
    logic [31:0] REQ_DATA_I;
    logic        REQ_WE_I;
    logic        RSP_VALID_O;
    logic [31:0] RSP_DATA_O;
    logic        RSP_ERR_O;
    logic [31:0] WB_ADD_O;
    logic [31:0] WB_DATA_O;
    logic [31:0] WB_DATA_I;
    logic        WB_STB_O;
    logic        WB_WE_O;
    logic        WB_ACK_I;
    logic        WB_VALID_I;

    modport master (
        input  REQ_VALID_I, REQ_ADD_I, REQ_DATA_I, REQ_WE_I, WB_DATA_I, WB_ACK_I, WB_VALID_I,
        output REQ_READY_O, RSP_VALID_O, RSP_DATA_O, RSP_ERR_O,
        output WB_ADD_O, WB_DATA_O, WB_STB_O, WB_WE_O
    );

    modport slave (
        output REQ_VALID_I, REQ_ADD_I, REQ_DATA_I, REQ_WE_I, WB_DATA_I, WB_ACK_I, WB_VALID_I,
        input  REQ_READY_O, RSP_VALID_O, RSP_DATA_O, RSP_ERR_O,
        input  WB_ADD_O, WB_DATA_O, WB_STB_O, WB_WE_O
    );
endinterface

// File: rtl/pci_wb_master.sv
// Single-beat bus master: one request in, one STB-qualified cycle out, one response back.
// Timeouts on both the bus phase and the handshake-release phase keep a dead slave from hanging it.
module pci_wb_master #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic             PHY_CLK33_I,
    input  logic             PHY_RST_I,
    pci_wb_master_if.master  bus
);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUS, RELEASE} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          ready_q, ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic          rsp_err_q, rsp_err_d;
    logic [31:0]   add_q, add_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          stb_q, stb_d;
    logic          we_q, we_d;
    logic          done, timeout;

    // Only the handshake matching the cycle direction completes it.
    assign done    = we_q ? bus.WB_ACK_I : bus.WB_VALID_I;
    assign timeout = (timer_q == TMAX);

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        ready_d     = ready_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        add_d       = add_q;
        wdata_d     = wdata_q;
        stb_d       = stb_q;
        we_d        = we_q;
        unique case (state_q)
            IDLE: begin
                if (bus.REQ_VALID_I) begin
                    add_d   = bus.REQ_ADD_I;
                    wdata_d = bus.REQ_DATA_I;
                    we_d    = bus.REQ_WE_I;
                    stb_d   = 1'b1;
                    timer_d = '0;
                    ready_d = 1'b0;
                    state_d = BUS;
                end
            end
            BUS: begin
                if (done || timeout) begin
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = ~done;
                    rsp_data_d  = we_q ? 32'h0 : (done ? bus.WB_DATA_I : ERR_DATA);
                    timer_d     = '0;
                    state_d     = RELEASE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RELEASE: begin
                // Wait for the slave to drop its level handshake before taking new work.
                if ((!bus.WB_ACK_I && !bus.WB_VALID_I) || timeout) begin
                    ready_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                ready_d = 1'b1;
                stb_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge PHY_CLK33_I or posedge PHY_RST_I) begin
        if (PHY_RST_I) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            add_q       <= '0;
            wdata_q     <= '0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            add_q       <= add_d;
            wdata_q     <= wdata_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
        end
    end

    assign bus.REQ_READY_O = ready_q;
    assign bus.RSP_VALID_O = rsp_valid_q;
    assign bus.RSP_DATA_O  = rsp_data_q;
    assign bus.RSP_ERR_O   = rsp_err_q;
    assign bus.WB_ADD_O    = add_q;
    assign bus.WB_DATA_O   = wdata_q;
    assign bus.WB_STB_O    = stb_q;
    assign bus.WB_WE_O     = we_q;
endmodule

// File: tb/tb_pci_wb_master.sv
// Directed bench for pci_wb_master with a registered one-cycle slave model and
// selectable misbehaving-slave modes (silent, ACK-only).
module tb_pci_wb_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   mode = 0;  // 0 normal slave, 1 never responds, 2 asserts only ACK

    pci_wb_master_if bus ();

    pci_wb_master #(.TIMEOUT_CYCLES(8), .ERR_DATA(32'hDEAD_BEEF)) dut (
        .PHY_CLK33_I (clk),
        .PHY_RST_I   (rst),
        .bus         (bus)
    );

    always #15 clk = ~clk;

    // Registered slave: level ACK/VALID asserted one edge after STB, dropped one edge after STB falls.
    logic [31:0] mem [16];
    logic        ack_q, vld_q;
    logic [31:0] rdata_q;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q   <= 1'b0;
            vld_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q <= bus.WB_STB_O && ((mode == 0) ? bus.WB_WE_O : (mode == 2));
            vld_q <= bus.WB_STB_O && (mode == 0) && !bus.WB_WE_O;
            if (bus.WB_STB_O && !bus.WB_WE_O) rdata_q <= mem[bus.WB_ADD_O[5:2]];
            if (bus.WB_STB_O && bus.WB_WE_O && mode == 0) mem[bus.WB_ADD_O[5:2]] <= bus.WB_DATA_O;
        end
    end
    assign bus.WB_ACK_I   = ack_q;
    assign bus.WB_VALID_I = vld_q;
    assign bus.WB_DATA_I  = rdata_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request from idle; report counts and the edge index (E0 = accept) of each event.
    task automatic do_req(input logic we, input logic [31:0] add, input logic [31:0] data,
                          output int stb_cyc, output int rsp_cnt, output int rsp_idx,
                          output logic err, output logic [31:0] rdata, output int rdy_edge,
                          output logic stable);
        stb_cyc = 0; rsp_cnt = 0; rsp_idx = -1; err = 1'bx; rdata = 'x; rdy_edge = -1; stable = 1'b1;
        @(negedge clk);
        bus.REQ_VALID_I = 1'b1;
        bus.REQ_WE_I    = we;
        bus.REQ_ADD_I   = add;
        bus.REQ_DATA_I  = data;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) begin
                bus.REQ_VALID_I = 1'b0;
                bus.REQ_ADD_I   = 32'hFFFF_FFF0;
                bus.REQ_DATA_I  = 32'h5555_AAAA;
                bus.REQ_WE_I    = ~we;
            end
            if (bus.WB_STB_O) begin
                stb_cyc++;
                if (bus.WB_ADD_O !== add || bus.WB_WE_O !== we || (we && bus.WB_DATA_O !== data))
                    stable = 1'b0;
            end
            if (bus.RSP_VALID_O) begin
                rsp_cnt++;
                rsp_idx = n - 1;
                err     = bus.RSP_ERR_O;
                rdata   = bus.RSP_DATA_O;
            end
            if (bus.REQ_READY_O) begin
                rdy_edge = n - 1;
                break;
            end
        end
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] add;
        logic [31:0] data;
        int          slave_mode;
        int          exp_stb;
        int          exp_rsp_idx;
        int          exp_rdy_edge;
        logic        exp_err;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int   stb_cyc, rsp_cnt, rsp_idx, rdy_edge;
        logic err, stable;
        logic [31:0] rdata;
        int   acc_cnt, rsp_total, last_acc;
        logic spacing_ok;

        //          name        we    add           data          mode stb rsp rdy err   data
        vecs[0] = '{"wr4",      1'b1, 32'h0000_0004, 32'h1234_5678, 0,  2,  2,  4, 1'b0, 32'h0};
        vecs[1] = '{"rd4",      1'b0, 32'h0000_0004, 32'h0,         0,  2,  2,  4, 1'b0, 32'h1234_5678};
        vecs[2] = '{"rd_to",    1'b0, 32'h0000_0008, 32'h0,         1,  8,  8,  9, 1'b1, 32'hDEAD_BEEF};
        vecs[3] = '{"wr_to",    1'b1, 32'h0000_000C, 32'h0000_A5A5, 1,  8,  8,  9, 1'b1, 32'h0};
        vecs[4] = '{"rd_ackonly",1'b0,32'h0000_0004, 32'h0,         2,  8,  8, 10, 1'b1, 32'hDEAD_BEEF};
        vecs[5] = '{"wr10",     1'b1, 32'h0000_0010, 32'hCAFE_F00D, 0,  2,  2,  4, 1'b0, 32'h0};
        vecs[6] = '{"rd10",     1'b0, 32'h0000_0010, 32'h0,         0,  2,  2,  4, 1'b0, 32'hCAFE_F00D};

        bus.REQ_VALID_I = 1'b0;
        bus.REQ_ADD_I   = '0;
        bus.REQ_DATA_I  = '0;
        bus.REQ_WE_I    = 1'b0;

        #40;
        chk("rst_ready", 32'(bus.REQ_READY_O), 32'd1);
        chk("rst_stb",   32'(bus.WB_STB_O),    32'd0);
        chk("rst_rspv",  32'(bus.RSP_VALID_O), 32'd0);
        chk("rst_err",   32'(bus.RSP_ERR_O),   32'd0);
        chk("rst_data",  bus.RSP_DATA_O,        32'd0);
        chk("rst_add",   bus.WB_ADD_O,          32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            mode = vecs[i].slave_mode;
            do_req(vecs[i].we, vecs[i].add, vecs[i].data,
                   stb_cyc, rsp_cnt, rsp_idx, err, rdata, rdy_edge, stable);
            chk({vecs[i].name, "_stb_cycles"}, 32'(stb_cyc),  32'(vecs[i].exp_stb));
            chk({vecs[i].name, "_rsp_count"},  32'(rsp_cnt),  32'd1);
            chk({vecs[i].name, "_rsp_edge"},   32'(rsp_idx),  32'(vecs[i].exp_rsp_idx));
            chk({vecs[i].name, "_rsp_err"},    32'(err),      32'(vecs[i].exp_err));
            chk({vecs[i].name, "_rsp_data"},   rdata,         vecs[i].exp_data);
            chk({vecs[i].name, "_ready_edge"}, 32'(rdy_edge), 32'(vecs[i].exp_rdy_edge));
            chk({vecs[i].name, "_bus_stable"}, 32'(stable),   32'd1);
            chk({vecs[i].name, "_hold_data"},  bus.RSP_DATA_O, vecs[i].exp_data);
        end

        // Back-to-back writes with REQ_VALID held: accepts every 5 edges, one response each.
        mode = 0;
        @(negedge clk);
        bus.REQ_VALID_I = 1'b1;
        bus.REQ_WE_I    = 1'b1;
        bus.REQ_ADD_I   = 32'h0000_0020;
        bus.REQ_DATA_I  = 32'h0BAD_F00D;
        acc_cnt = 0; rsp_total = 0; last_acc = -1; spacing_ok = 1'b1;
        for (int n = 0; n <= 26; n++) begin
            if (n > 0) @(negedge clk);
            if (n == 18) bus.REQ_VALID_I = 1'b0;
            if (bus.RSP_VALID_O) rsp_total++;
            if (bus.REQ_VALID_I && bus.REQ_READY_O) begin
                if (last_acc >= 0 && n - last_acc != 5) spacing_ok = 1'b0;
                last_acc = n;
                acc_cnt++;
            end
        end
        chk("b2b_accepts",   32'(acc_cnt),    32'd4);
        chk("b2b_responses", 32'(rsp_total),  32'd4);
        chk("b2b_spacing",   32'(spacing_ok), 32'd1);

        // Reset while STB is high on a stalled read.
        mode = 1;
        @(negedge clk);
        bus.REQ_VALID_I = 1'b1;
        bus.REQ_WE_I    = 1'b0;
        bus.REQ_ADD_I   = 32'h0000_0030;
        @(negedge clk);
        bus.REQ_VALID_I = 1'b0;
        @(negedge clk);
        chk("mid_stb_before", 32'(bus.WB_STB_O), 32'd1);
        @(posedge clk);
        #5 rst = 1'b1;
        #1;
        chk("mid_rst_stb",   32'(bus.WB_STB_O),    32'd0);
        chk("mid_rst_rspv",  32'(bus.RSP_VALID_O), 32'd0);
        chk("mid_rst_ready", 32'(bus.REQ_READY_O), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        rsp_total = 0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (bus.RSP_VALID_O || bus.WB_STB_O || !bus.REQ_READY_O) rsp_total++;
        end
        chk("post_rst_quiet", 32'(rsp_total), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
